// File: rtl/spi_stream_pkg.sv
// Shared types for the SPI read-data packing path.
// Word bundle, FSM states and the byte-lane keep helper.
package spi_stream_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic {
        IDLE,
        RUN
    } packer_state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    // Keep mask for a word holding 'lanes' bytes (1..4).
    function automatic logic [3:0] keep_mask(input logic [2:0] lanes);
        logic [4:0] m;
        m = (5'd1 << lanes) - 5'd1;
        return m[3:0];
    endfunction

endpackage

// File: rtl/spi_word_outreg.sv
// One-entry AXI-Stream output register for packed words.
// Ports: clk_i, rst_ni, word_i/load_i (fill), ready_i (sink ready),
//   word_o/valid_o (stream side), full_o, hold_o (filled and not
//   draining this cycle, so a new word cannot be loaded).
module spi_word_outreg
    import spi_stream_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_ni,
    input  word_t word_i,
    input  logic  load_i,
    input  logic  ready_i,
    output word_t word_o,
    output logic  valid_o,
    output logic  full_o,
    output logic  hold_o
);

    word_t word_q, word_d;
    logic  full_q, full_d;
    logic  accept;

    assign accept  = full_q & ready_i;
    assign hold_o  = full_q & ~accept;
    assign word_o  = word_q;
    assign valid_o = full_q;
    assign full_o  = full_q;

    always_comb begin
        word_d = word_q;
        full_d = full_q;
        if (load_i) begin
            word_d = word_i;
            full_d = 1'b1;
        end else if (accept) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
            full_q <= 1'b0;
        end else begin
            word_q <= word_d;
            full_q <= full_d;
        end
    end

endmodule

// File: rtl/spi_fifo_packer.sv
// Drains SPI read-back bytes from the FIFO, packs them little-endian
// into 32-bit words and streams them out, tlast on the frame's end.
// Ports: clk, rstn (async, active-low); start/frame_bytes begin a
//   frame; fifo_not_empty/fifo_dout/fifo_rd_en read the FIFO (data
//   one cycle after the strobe); m_axis_* is the AXIS master;
//   busy while a frame runs, done pulses once when it ends.
module spi_fifo_packer
    import spi_stream_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_bytes,
    input  logic             fifo_not_empty,
    input  logic [7:0]       fifo_dout,
    output logic             fifo_rd_en,
    output logic [31:0]      m_axis_tdata,
    output logic [3:0]       m_axis_tkeep,
    output logic             m_axis_tlast,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             busy,
    output logic             done
);

    packer_state_t    state_q, state_d;
    logic [LEN_W-1:0] req_left_q, req_left_d;
    logic [LEN_W-1:0] rem_left_q, rem_left_d;
    logic [2:0]       lane_q, lane_d;
    logic             pend_q, pend_d;
    logic             hold_q, hold_d;
    logic             done_q, done_d;
    logic [31:0]      asm_q, asm_d;

    logic [31:0]      asm_cap;
    logic [2:0]       lane_cap;
    logic [LEN_W-1:0] rem_cap;
    logic             cap_done;
    logic             rd_en;
    logic             load;
    logic             accept;
    logic             out_full;
    logic             asm_hold;
    word_t            word_in;
    word_t            word_out;

    // Assembly word as it looks after this cycle's capture. While a
    // completed word is held no read is in flight, so pend_q is 0 and
    // these equal the held values.
    always_comb begin
        asm_cap = asm_q;
        if (pend_q) begin
            asm_cap[{lane_q[1:0], 3'b000} +: 8] = fifo_dout;
        end
        lane_cap = lane_q + {2'b00, pend_q};
        rem_cap  = rem_left_q - LEN_W'(pend_q);
        cap_done = pend_q & ((lane_cap == 3'd4) | (rem_cap == '0));
    end

    assign word_in.data = asm_cap;
    assign word_in.keep = keep_mask(lane_cap);
    assign word_in.last = (rem_cap == '0);

    assign load   = (cap_done | hold_q) & ~asm_hold;
    assign accept = m_axis_tvalid & m_axis_tready;

    // lane_cap counts bytes captured or landing this cycle. A read for
    // the next word may start while the 4th byte lands, but only when
    // the output register is empty so that word is certain to move
    // out and free the lanes; this keeps 1 byte/cycle with no
    // dependence on tready.
    always_comb begin
        rd_en = (state_q == RUN) & fifo_not_empty &
                (req_left_q != '0) & ~hold_q &
                ((lane_cap < 3'd4) |
                 ((lane_cap == 3'd4) & ~out_full));
    end

    always_comb begin
        state_d    = state_q;
        req_left_d = req_left_q - LEN_W'(rd_en);
        rem_left_d = rem_cap;
        lane_d     = lane_cap;
        pend_d     = rd_en;
        hold_d     = hold_q;
        asm_d      = asm_cap;
        done_d     = 1'b0;

        if (load) begin
            lane_d = '0;
            asm_d  = '0;
            hold_d = 1'b0;
        end else if (cap_done) begin
            hold_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (frame_bytes != '0) begin
                        state_d    = RUN;
                        req_left_d = frame_bytes;
                        rem_left_d = frame_bytes;
                        lane_d     = '0;
                        pend_d     = 1'b0;
                        hold_d     = 1'b0;
                        asm_d      = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (accept && word_out.last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            req_left_q <= '0;
            rem_left_q <= '0;
            lane_q     <= '0;
            pend_q     <= 1'b0;
            hold_q     <= 1'b0;
            done_q     <= 1'b0;
            asm_q      <= '0;
        end else begin
            state_q    <= state_d;
            req_left_q <= req_left_d;
            rem_left_q <= rem_left_d;
            lane_q     <= lane_d;
            pend_q     <= pend_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            asm_q      <= asm_d;
        end
    end

    spi_word_outreg u_outreg (
        .clk_i   (clk),
        .rst_ni  (rstn),
        .word_i  (word_in),
        .load_i  (load),
        .ready_i (m_axis_tready),
        .word_o  (word_out),
        .valid_o (m_axis_tvalid),
        .full_o  (out_full),
        .hold_o  (asm_hold)
    );

    assign fifo_rd_en   = rd_en;
    assign m_axis_tdata = word_out.data;
    assign m_axis_tkeep = word_out.keep;
    assign m_axis_tlast = word_out.last;
    assign busy         = (state_q == RUN);
    assign done         = done_q;

endmodule

// File: tb/tb_spi_fifo_packer.sv
// Self-checking bench for spi_fifo_packer: FIFO model, queue-based
// word reference, table vectors, corner sequences, random frames.
module tb_spi_fifo_packer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [7:0]  frame_bytes;
    logic        fifo_not_empty;
    logic [7:0]  fifo_dout;
    logic        fifo_rd_en;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    spi_fifo_packer #(.LEN_W(8)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .start          (start),
        .frame_bytes    (frame_bytes),
        .fifo_not_empty (fifo_not_empty),
        .fifo_dout      (fifo_dout),
        .fifo_rd_en     (fifo_rd_en),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .busy           (busy),
        .done           (done)
    );

    typedef struct {
        int          n;
        logic [7:0]  base;
        logic [7:0]  step;
        logic [31:0] w0;
        logic [3:0]  k0;
        logic        last0;
        logic [31:0] wl;
        logic [3:0]  kl;
        int          beats;
    } vec_t;

    int          nchecks = 0;
    int          nerrs = 0;
    logic [7:0]  src_q[$];
    logic [7:0]  fifo_q[$];
    logic [36:0] exp_q[$];
    int          rd_count, done_count, beat_count, cyc;
    int          first_valid_cyc, last_rd_cyc;
    int          feed_gap, feed_cnt;
    logic [36:0] got_first, got_last, prev_beat;
    bit          prev_stall;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic update_ne();
        fifo_not_empty = (fifo_q.size() != 0);
    endtask

    // Reference: split the frame's bytes into 4-byte little-endian
    // words; short tail zero-padded, last word flagged.
    task automatic build_exp();
        logic [7:0]  b[$];
        logic [31:0] d;
        logic [3:0]  k;
        b = src_q;
        exp_q.delete();
        for (int i = 0; i < b.size(); i += 4) begin
            d = '0;
            k = '0;
            for (int j = 0; j < 4; j++) begin
                if (i + j < b.size()) begin
                    d[8*j +: 8] = b[i+j];
                    k[j] = 1'b1;
                end
            end
            exp_q.push_back({d, k, (i + 4 >= b.size())});
        end
    endtask

    task automatic tick();
        logic        rd;
        logic        acc;
        logic [36:0] beat;
        #1;
        rd   = fifo_rd_en;
        acc  = m_axis_tvalid & m_axis_tready;
        beat = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
        if (rd) begin
            rd_count++;
            last_rd_cyc = cyc;
            chk("read_nonempty", 64'(fifo_q.size() != 0), 64'd1);
        end
        if (prev_stall)
            chk("stall_stable", 64'({m_axis_tvalid, beat}),
                64'({1'b1, prev_beat}));
        if (m_axis_tvalid && first_valid_cyc < 0)
            first_valid_cyc = cyc;
        if (acc) begin
            if (beat_count == 0) got_first = beat;
            got_last = beat;
            beat_count++;
            chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0)
                chk("beat", 64'(beat), 64'(exp_q.pop_front()));
        end
        if (done) done_count++;
        prev_stall = m_axis_tvalid & ~m_axis_tready;
        prev_beat  = beat;
        @(posedge clk);
        #1;
        if (rd && fifo_q.size() != 0) fifo_dout = fifo_q.pop_front();
        if (src_q.size() != 0) begin
            if (feed_gap == 0) begin
                while (src_q.size() != 0) fifo_q.push_back(src_q.pop_front());
            end else begin
                feed_cnt++;
                if (feed_cnt >= feed_gap) begin
                    feed_cnt = 0;
                    fifo_q.push_back(src_q.pop_front());
                end
            end
        end
        cyc++;
        @(negedge clk);
        update_ne();
    endtask

    task automatic start_frame(input int n, input int gap);
        build_exp();
        rd_count = 0;
        done_count = 0;
        beat_count = 0;
        first_valid_cyc = -1;
        feed_gap = gap;
        feed_cnt = 0;
        if (gap == 0)
            while (src_q.size() != 0) fifo_q.push_back(src_q.pop_front());
        update_ne();
        start = 1'b1;
        frame_bytes = 8'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_done(input int rpct, input int budget);
        int k;
        k = 0;
        while (done_count == 0 && k < budget) begin
            m_axis_tready = ($urandom_range(0, 99) < rpct);
            tick();
            k++;
        end
        chk("frame_done", 64'(done_count != 0), 64'd1);
    endtask

    task automatic finish_frame(input int n);
        m_axis_tready = 1'b1;
        tick();
        chk("done_once", 64'(done_count), 64'd1);
        chk("rd_count", 64'(rd_count), 64'(n));
        chk("beats_left", 64'(exp_q.size()), 64'd0);
        chk("busy_idle", 64'(busy), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string p);
        chk({p, "_rd_en"}, 64'(fifo_rd_en), 64'd0);
        chk({p, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
        chk({p, "_tdata"}, 64'(m_axis_tdata), 64'd0);
        chk({p, "_tkeep"}, 64'(m_axis_tkeep), 64'd0);
        chk({p, "_tlast"}, 64'(m_axis_tlast), 64'd0);
        chk({p, "_busy"}, 64'(busy), 64'd0);
        chk({p, "_done"}, 64'(done), 64'd0);
    endtask

    vec_t vecs[7];

    initial begin
        int k;
        int n;
        bit saw;

        vecs[0] = '{8, 8'h01, 8'h01, 32'h04030201, 4'hF, 1'b0,
                    32'h08070605, 4'hF, 2};
        vecs[1] = '{5, 8'hAA, 8'h11, 32'hDDCCBBAA, 4'hF, 1'b0,
                    32'h000000EE, 4'h1, 2};
        vecs[2] = '{1, 8'h5A, 8'h00, 32'h0000005A, 4'h1, 1'b1,
                    32'h0000005A, 4'h1, 1};
        vecs[3] = '{3, 8'h10, 8'h01, 32'h00121110, 4'h7, 1'b1,
                    32'h00121110, 4'h7, 1};
        vecs[4] = '{6, 8'hF0, 8'h01, 32'hF3F2F1F0, 4'hF, 1'b0,
                    32'h0000F5F4, 4'h3, 2};
        vecs[5] = '{4, 8'hC0, 8'h01, 32'hC3C2C1C0, 4'hF, 1'b1,
                    32'hC3C2C1C0, 4'hF, 1};
        vecs[6] = '{255, 8'h00, 8'h01, 32'h03020100, 4'hF, 1'b0,
                    32'h00FEFDFC, 4'h7, 64};

        rstn = 1'b0;
        start = 1'b0;
        frame_bytes = '0;
        fifo_not_empty = 1'b0;
        fifo_dout = '0;
        m_axis_tready = 1'b0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_beat = '0;
        feed_gap = 0;
        feed_cnt = 0;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // Table vectors, FIFO preloaded, sink always ready
        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < vecs[v].n; i++)
                src_q.push_back(8'(vecs[v].base + vecs[v].step * 8'(i)));
            start_frame(vecs[v].n, 0);
            run_until_done(100, 4 * vecs[v].n + 100);
            chk("tbl_first", 64'(got_first),
                64'({vecs[v].w0, vecs[v].k0, vecs[v].last0}));
            chk("tbl_last", 64'(got_last),
                64'({vecs[v].wl, vecs[v].kl, 1'b1}));
            chk("tbl_beats", 64'(beat_count), 64'(vecs[v].beats));
            finish_frame(vecs[v].n);
        end

        // Latency: 4th read to tvalid
        for (int i = 0; i < 4; i++) src_q.push_back(8'(8'h40 + 8'(i)));
        m_axis_tready = 1'b1;
        start_frame(4, 0);
        run_until_done(100, 100);
        chk("latency", 64'(first_valid_cyc - last_rd_cyc), 64'd2);
        finish_frame(4);

        // Zero-length frame
        start_frame(0, 0);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_busy", 64'(busy), 64'd0);
        tick();
        chk("zero_done_pulse", 64'(done), 64'd0);
        chk("zero_done_count", 64'(done_count), 64'd1);
        chk("zero_beats", 64'(beat_count), 64'd0);

        // Start during RUN is ignored
        for (int i = 0; i < 8; i++) src_q.push_back(8'(8'h60 + 8'(i)));
        start_frame(8, 0);
        m_axis_tready = 1'b1;
        tick();
        tick();
        start = 1'b1;
        frame_bytes = 8'd4;
        tick();
        start = 1'b0;
        run_until_done(100, 100);
        chk("overlap_beats", 64'(beat_count), 64'd2);
        finish_frame(8);

        // Backpressure: sink stalls 10 cycles after the first tvalid
        for (int i = 0; i < 12; i++) src_q.push_back(8'(8'h21 + 8'(i)));
        m_axis_tready = 1'b0;
        start_frame(12, 0);
        k = 0;
        while (!m_axis_tvalid && k < 30) begin
            tick();
            k++;
        end
        chk("bp_valid_seen", 64'(m_axis_tvalid), 64'd1);
        repeat (10) tick();
        chk("bp_reads_halted", 64'(rd_count), 64'd8);
        chk("bp_beat0", 64'({m_axis_tvalid, m_axis_tdata, m_axis_tkeep}),
            64'({1'b1, 32'h24232221, 4'hF}));
        run_until_done(100, 100);
        chk("bp_beats", 64'(beat_count), 64'd3);
        finish_frame(12);

        // FIFO starvation: one byte per 20 cycles
        for (int i = 0; i < 4; i++) src_q.push_back(8'(8'h91 + 8'(i)));
        m_axis_tready = 1'b1;
        start_frame(4, 20);
        k = 0;
        saw = 1'b0;
        while (rd_count < 4 && k < 300) begin
            tick();
            if (m_axis_tvalid) saw = 1'b1;
            k++;
        end
        chk("starve_reads", 64'(rd_count), 64'd4);
        chk("starve_no_early", 64'(saw), 64'd0);
        run_until_done(100, 100);
        chk("starve_beat", 64'(got_last), 64'({32'h94939291, 4'hF, 1'b1}));
        finish_frame(4);

        // Reset mid-frame after 3 reads
        for (int i = 0; i < 8; i++) src_q.push_back(8'(8'hA0 + 8'(i)));
        m_axis_tready = 1'b1;
        start_frame(8, 0);
        k = 0;
        while (rd_count < 3 && k < 50) begin
            tick();
            k++;
        end
        chk("rst_mid_reads", 64'(rd_count), 64'd3);
        rstn = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        fifo_q.delete();
        src_q.delete();
        exp_q.delete();
        update_ne();
        prev_stall = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) src_q.push_back(8'(8'hE1 + 8'(i)));
        start_frame(4, 0);
        run_until_done(100, 100);
        chk("rst_new_beat", 64'(got_first),
            64'({32'hE4E3E2E1, 4'hF, 1'b1}));
        finish_frame(4);

        // Random frames against the reference
        for (int r = 0; r < 15; r++) begin
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) src_q.push_back(8'($urandom));
            start_frame(n, $urandom_range(0, 3));
            run_until_done($urandom_range(30, 100), 20 * n + 200);
            finish_frame(n);
        end

        $display("CHECKS %0d ERRORS %0d", nchecks, nerrs);
        $finish;
    end

endmodule
